// File: rtl/dmem_pkg.sv
// Shared types and widths for the MEM-stage data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_byte_en;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_data;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byte_en,
    input  req_ready, resp_valid, resp_data, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byte_en,
    output req_ready, resp_valid, resp_data, resp_err, busy
  );

endinterface

// File: rtl/dmem_word_array.sv
// Word-organised data RAM: one synchronous byte-lane write port, one combinational read port.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset so a committed store survives a later reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = (32'(raddr) < 32'(DEPTH_WORDS)) ? mem[raddr] : '0;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, one response pulse per request.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic              started;
  logic              accept, commit;
  logic              lat_write;
  logic [31:0]       lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;
  logic [WORD_W-1:0] resp_data_q;
  logic              resp_err_q;
  logic              addr_err;
  logic              ram_we;
  logic [AW-1:0]     word_idx;
  logic [WORD_W-1:0] ram_rdata;

  assign addr_err = (lat_addr[1:0] != 2'b00) ||
                    ({2'b00, lat_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign word_idx = lat_addr[AW+1:2];
  assign ram_we   = commit && lat_write && !addr_err;

  dmem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_idx),
    .wdata (lat_wdata),
    .be    (lat_be),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  // started keeps ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      started     <= 1'b0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_next;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        lat_be    <= bus.req_byte_en;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_err_q  <= addr_err;
        resp_data_q <= (addr_err || lat_write) ? '0 : ram_rdata;
      end
    end
  end

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    commit         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.resp_err   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = started;
        if (bus.req_valid && started) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        bus.busy = 1'b1;
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = resp_data_q;
        bus.resp_err   = resp_err_q;
        bus.req_ready  = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 2, 1 and 3 behind one shared stimulus driver.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  int          lat_tab [3] = '{2, 1, 3};
  exp_t        exp_q [$];

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_byte_en = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus_l2 ();
  dmem_responder_if bus_l1 ();
  dmem_responder_if bus_l3 ();

  assign bus_l2.req_valid   = req_valid && (sel == 0);
  assign bus_l2.req_write   = req_write;
  assign bus_l2.req_addr    = req_addr;
  assign bus_l2.req_wdata   = req_wdata;
  assign bus_l2.req_byte_en = req_byte_en;
  assign bus_l1.req_valid   = req_valid && (sel == 1);
  assign bus_l1.req_write   = req_write;
  assign bus_l1.req_addr    = req_addr;
  assign bus_l1.req_wdata   = req_wdata;
  assign bus_l1.req_byte_en = req_byte_en;
  assign bus_l3.req_valid   = req_valid && (sel == 2);
  assign bus_l3.req_write   = req_write;
  assign bus_l3.req_addr    = req_addr;
  assign bus_l3.req_wdata   = req_wdata;
  assign bus_l3.req_byte_en = req_byte_en;

  assign req_ready  = (sel == 0) ? bus_l2.req_ready  : (sel == 1) ? bus_l1.req_ready  : bus_l3.req_ready;
  assign resp_valid = (sel == 0) ? bus_l2.resp_valid : (sel == 1) ? bus_l1.resp_valid : bus_l3.resp_valid;
  assign resp_data  = (sel == 0) ? bus_l2.resp_data  : (sel == 1) ? bus_l1.resp_data  : bus_l3.resp_data;
  assign resp_err   = (sel == 0) ? bus_l2.resp_err   : (sel == 1) ? bus_l1.resp_err   : bus_l3.resp_err;
  assign busy       = (sel == 0) ? bus_l2.busy       : (sel == 1) ? bus_l1.busy       : bus_l3.busy;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_l2 (.clk(clk), .rst_n(rst_n), .bus(bus_l2));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_l1 (.clk(clk), .rst_n(rst_n), .bus(bus_l1));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut_l3 (.clk(clk), .rst_n(rst_n), .bus(bus_l3));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drives one request, waits for it to be taken and records the expected response.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] exp_data,
                               input logic exp_err, input bit expect_resp, output int acc_edge);
    int   waited = 0;
    exp_t item;
    @(negedge clk);
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wdata;
    req_byte_en = be;
    req_valid   = 1'b1;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      $display("[TB] FAIL accept timeout: req_ready stayed %b, expected 1 (addr %h)", req_ready, addr);
      req_valid = 1'b0;
      acc_edge  = -1;
      return;
    end
    acc_edge = cyc + 1;
    if (expect_resp) begin
      item.data = exp_data;
      item.err  = exp_err;
      item.due  = cyc + 1 + lat_tab[sel];
      exp_q.push_back(item);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every response pulse must match the oldest expected entry, on its due cycle.
  always @(negedge clk) begin
    exp_t item;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected response: resp_valid=1 data=%h, expected no response", resp_data);
      end else begin
        item = exp_q.pop_front();
        checkOutput("resp_data", resp_data, item.data);
        checkOutput("resp_err", 32'(resp_err), 32'(item.err));
        checkOutput("resp_cycle", 32'(cyc), 32'(item.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e, prev;
    logic [31:0] d;

    // Reset held with a request pending
    req_valid = 1'b1;
    req_addr  = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1;
    #1 checkOutput("ready before first edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready after release", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);

    // Store then load
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1'b1, e);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1, e);
    waitDrain();

    // Byte lanes: 0101 writes lanes 0 and 2; 0000 is an ack with no change
    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0, 1'b1, e);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b1, e);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b1, e);
    applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1'b1, e);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1'b1, e);
    waitDrain();

    // Errors and address boundaries
    applyStimulus(1'b1, 32'h0, 32'h01020304, 4'b1111, 32'h0, 1'b0, 1'b1, e);
    applyStimulus(1'b0, 32'h13, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1, e);
    applyStimulus(1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 1'b1, e);
    applyStimulus(1'b1, 32'h2, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 1'b1, e);
    applyStimulus(1'b0, 32'hFFFFFFFC, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1, e);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'b0000, 32'h01020304, 1'b0, 1'b1, e);
    applyStimulus(1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 1'b1, e);
    applyStimulus(1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 1'b1, e);
    waitDrain();

    // Reset while a store waits: it must be dropped with no response
    applyStimulus(1'b1, 32'h40, 32'h12345678, 4'b1111, 32'h0, 1'b0, 1'b1, e);
    waitDrain();
    applyStimulus(1'b1, 32'h40, 32'h00000055, 4'b1111, 32'h0, 1'b0, 1'b0, e);
    checkOutput("busy before mid-op reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid-op reset busy", 32'(busy), 32'd0);
    checkOutput("mid-op reset resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 32'h40, 32'h0, 4'b0000, 32'h12345678, 1'b0, 1'b1, e);
    waitDrain();

    // Back-to-back on each latency: acceptances spaced LATENCY+1 edges apart
    for (int s = 0; s < 3; s++) begin
      sel = s;
      @(negedge clk);
      prev = 0;
      for (int k = 0; k < 4; k++) begin
        d = 32'h5A000000 | (32'(s) << 8) | 32'(k);
        applyStimulus(1'b1, 32'h80 + 32'(4 * k), d, 4'b1111, 32'h0, 1'b0, 1'b1, e);
        if (k > 0) checkOutput("b2b store gap", 32'(e - prev), 32'(lat_tab[s] + 1));
        prev = e;
      end
      for (int k = 0; k < 4; k++) begin
        d = 32'h5A000000 | (32'(s) << 8) | 32'(k);
        applyStimulus(1'b0, 32'h80 + 32'(4 * k), 32'h0, 4'b0000, d, 1'b0, 1'b1, e);
        checkOutput("b2b load gap", 32'(e - prev), 32'(lat_tab[s] + 1));
        prev = e;
      end
      waitDrain();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
